sw_seq_ctrl: RTL and testbench

//  Step sequencer for the panel switch matrix. It walks a programmable table of up to NSTEP steps.

---
 rtl/sw_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sw_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_seq_ctrl.sv
// Step sequencer for the panel switch matrix: walks a table of {pattern, tunit, tlen}
// entries, drives each pattern and times its hold through the downstream timer.
module sw_seq_ctrl #(
    parameter int               NSTEP    = 8,
    parameter int               SW_W     = 8,
    parameter logic [SW_W-1:0]  SAFE_PAT = {SW_W{1'b0}},
    localparam int              AW       = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [SW_W+17:0] cfg_data,
    input  logic [AW:0]     num_steps,
    input  logic            seq_go,
    input  logic            seq_abort,
    input  logic            tmr_pulse,
    output logic            tmr_start,
    output logic [1:0]      tmr_tunit,
    output logic [15:0]     tmr_tlen,
    output logic [SW_W-1:0] sw_out,
    output logic [AW-1:0]   step_idx,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            cfg_err
);

    typedef struct packed {
        logic [SW_W-1:0] pat;
        logic [1:0]      tunit;
        logic [15:0]     tlen;
    } entry_t;

    typedef enum logic [2:0] {IDLE, APPLY, WAIT, DRAIN, FIN} state_t;

    state_t          state, state_n;
    entry_t          tbl [NSTEP];
    entry_t          ent;
    logic [AW:0]     nsteps, nsteps_n;
    logic [AW-1:0]   idx_n;
    logic [SW_W-1:0] sw_n;
    logic [1:0]      tunit_n;
    logic [15:0]     tlen_n;
    logic            start_n, busy_n, done_n, abort_n, err_n, load, last;

    // Table is plain RAM: frozen while a run is in progress, no reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE && int'(cfg_addr) < NSTEP)
            tbl[cfg_addr] <= entry_t'(cfg_data);
    end

    assign last = ({1'b0, step_idx} + (AW+1)'(1)) == nsteps;

    always_comb begin
        state_n  = state;
        idx_n    = step_idx;
        nsteps_n = nsteps;
        sw_n     = sw_out;
        tunit_n  = tmr_tunit;
        tlen_n   = tmr_tlen;
        start_n  = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        err_n    = cfg_err;
        load     = 1'b0;
        ent      = '0;
        unique case (state)
            IDLE: if (seq_go) begin
                err_n = 1'b0;
                if (num_steps != '0 && int'(num_steps) <= NSTEP) begin
                    nsteps_n = num_steps;
                    idx_n    = '0;
                    load     = 1'b1;
                    busy_n   = 1'b1;
                    state_n  = APPLY;
                end else begin
                    done_n = 1'b1;
                end
            end
            APPLY: begin
                if (tmr_tunit == 2'b11) err_n = 1'b1;
                if (seq_abort) begin
                    sw_n = SAFE_PAT;
                    // tmr_start is high this cycle iff the timer has been armed
                    if (tmr_start) state_n = DRAIN;
                    else begin
                        state_n = IDLE;
                        abort_n = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else if (tmr_start) begin
                    state_n = WAIT;
                end else if (last) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                end else begin
                    idx_n   = step_idx + 1'b1;
                    load    = 1'b1;
                    state_n = APPLY;
                end
            end
            WAIT: begin
                if (seq_abort) begin
                    sw_n = SAFE_PAT;
                    if (tmr_pulse) begin
                        state_n = IDLE;
                        abort_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (tmr_pulse) begin
                    if (last) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = step_idx + 1'b1;
                        load    = 1'b1;
                        state_n = APPLY;
                    end
                end
            end
            DRAIN: if (tmr_pulse) begin
                state_n = IDLE;
                abort_n = 1'b1;
                busy_n  = 1'b0;
            end
            FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
                if (seq_abort) begin
                    sw_n    = SAFE_PAT;
                    abort_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Entering APPLY: present the step and arm the timer only for a real delay
        if (load) begin
            ent     = tbl[idx_n];
            sw_n    = ent.pat;
            tunit_n = ent.tunit;
            tlen_n  = ent.tlen;
            start_n = (ent.tlen != '0) && (ent.tunit != 2'b11);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nsteps    <= '0;
            step_idx  <= '0;
            sw_out    <= SAFE_PAT;
            tmr_tunit <= '0;
            tmr_tlen  <= '0;
            tmr_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            nsteps    <= nsteps_n;
            step_idx  <= idx_n;
            sw_out    <= sw_n;
            tmr_tunit <= tunit_n;
            tmr_tlen  <= tlen_n;
            tmr_start <= start_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= abort_n;
            cfg_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_sw_seq_ctrl.sv
// Bench for sw_seq_ctrl: behavioural timer, table model and an event scoreboard
// of timer starts, done and aborted pulses.
module tb_sw_seq_ctrl;
    localparam int NSTEP = 8;
    localparam int SW_W  = 8;
    localparam int AW    = 3;
    localparam logic [7:0] SAFE = 8'h00;

    logic clk = 0, rst_n = 0;
    logic cfg_we = 0, seq_go = 0, seq_abort = 0, tmr_pulse;
    logic [AW-1:0] cfg_addr = '0;
    logic [SW_W+17:0] cfg_data = '0;
    logic [AW:0] num_steps = '0;
    logic tmr_start, busy, done, aborted, cfg_err;
    logic [1:0] tmr_tunit;
    logic [15:0] tmr_tlen;
    logic [SW_W-1:0] sw_out;
    logic [AW-1:0] step_idx;

    sw_seq_ctrl #(.NSTEP(NSTEP), .SW_W(SW_W), .SAFE_PAT(SAFE)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .num_steps(num_steps), .seq_go(seq_go),
        .seq_abort(seq_abort), .tmr_pulse(tmr_pulse), .tmr_start(tmr_start),
        .tmr_tunit(tmr_tunit), .tmr_tlen(tmr_tlen), .sw_out(sw_out),
        .step_idx(step_idx), .busy(busy), .done(done), .aborted(aborted),
        .cfg_err(cfg_err));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // scaled-down timer: us=1, ms=4, s=16 cycles per unit
    int tcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 0;
            tmr_pulse <= 1'b0;
        end else begin
            tmr_pulse <= 1'b0;
            if (tmr_start)
                tcnt <= int'(tmr_tlen) * (tmr_tunit == 2'd0 ? 1 : tmr_tunit == 2'd1 ? 4 : 16);
            else if (tcnt > 0) begin
                if (tcnt == 1) tmr_pulse <= 1'b1;
                tcnt <= tcnt - 1;
            end
        end
    end

    function automatic logic [31:0] ev(input int k, input int idx, input logic [7:0] pat,
                                       input logic [1:0] tu, input logic [15:0] tl);
        return {2'(k), 4'(idx), pat, tu, tl};
    endfunction

    logic [31:0] sbq[$];
    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] e;
            if (tmr_start) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : 32'h0;
                chk("ev_start", ev(1, int'(step_idx), sw_out, tmr_tunit, tmr_tlen), e);
            end
            if (done) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : 32'h0;
                chk("ev_done", ev(2, 0, sw_out, 2'd0, 16'd0), e);
            end
            if (aborted) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : 32'h0;
                chk("ev_abort", ev(3, 0, sw_out, 2'd0, 16'd0), e);
            end
        end
    end

    int c22 = 0;
    logic busy_seen = 0;
    always @(negedge clk) begin
        if (rst_n && busy && sw_out == 8'h22) c22++;
        if (busy) busy_seen = 1;
    end

    logic [7:0] m_pat [NSTEP];
    logic [1:0] m_tu [NSTEP];
    logic [15:0] m_tl [NSTEP];
    logic [7:0] m_sw = SAFE;

    task automatic wr(input int a, input logic [7:0] p, input logic [1:0] tu, input logic [15:0] tl);
        @(negedge clk);
        cfg_we = 1; cfg_addr = AW'(a); cfg_data = {p, tu, tl};
        m_pat[a] = p; m_tu[a] = tu; m_tl[a] = tl;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic pulse_go(input int n);
        @(negedge clk);
        seq_go = 1; num_steps = (AW+1)'(n);
        @(negedge clk);
        seq_go = 0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_start();
        int i;
        for (i = 0; i < 100 && !tmr_start; i++) @(negedge clk);
        chk("start_timeout", 32'(tmr_start), 32'd1);
    endtask

    task automatic run(input int n);
        if (n >= 1 && n <= NSTEP) begin
            for (int i = 0; i < n; i++)
                if (m_tl[i] != 0 && m_tu[i] != 2'b11)
                    sbq.push_back(ev(1, i, m_pat[i], m_tu[i], m_tl[i]));
            m_sw = m_pat[n-1];
        end
        sbq.push_back(ev(2, 0, m_sw, 2'd0, 16'd0));
        pulse_go(n);
        wait_idle();
    endtask

    initial begin
        #12;
        chk("rst_sw", 32'(sw_out), 32'(SAFE));
        chk("rst_outs", {busy, done, aborted, cfg_err, tmr_start, 24'(step_idx)}, 32'd0);
        rst_n = 1;

        // T1: three timed steps
        wr(0, 8'hA5, 2'd0, 16'd10); wr(1, 8'h3C, 2'd1, 16'd2); wr(2, 8'hFF, 2'd0, 16'd5);
        run(3);
        chk("t1_sw_hold", 32'(sw_out), 32'hFF);
        chk("t1_busy", 32'(busy), 32'd0);

        // T2: zero-length middle step is held exactly one cycle, no start
        wr(0, 8'h11, 2'd0, 16'd4); wr(1, 8'h22, 2'd0, 16'd0); wr(2, 8'h33, 2'd0, 16'd4);
        c22 = 0;
        run(3);
        chk("t2_hold1", 32'(c22), 32'd1);

        // T3: abort while waiting -> safe pattern, drain, aborted
        wr(0, 8'h5A, 2'd0, 16'd20);
        sbq.push_back(ev(1, 0, 8'h5A, 2'd0, 16'd20));
        sbq.push_back(ev(3, 0, SAFE, 2'd0, 16'd0));
        pulse_go(1);
        wait_start();
        repeat (3) @(negedge clk);
        seq_abort = 1;
        @(negedge clk);
        seq_abort = 0;
        chk("t3_safe", 32'(sw_out), 32'(SAFE));
        chk("t3_draining", 32'(busy), 32'd1);
        wait_idle();
        m_sw = SAFE;
        run(1);

        // T4: num_steps 0 and out of range -> immediate done, no run
        busy_seen = 0;
        run(0);
        run(9);
        chk("t4_no_busy", 32'(busy_seen), 32'd0);

        // T5: go/cfg_we ignored while busy; tunit=11 skipped and flagged
        wr(0, 8'hC3, 2'd0, 16'd6); wr(1, 8'h77, 2'd3, 16'd5); wr(2, 8'hE1, 2'd0, 16'd3);
        sbq.push_back(ev(1, 0, 8'hC3, 2'd0, 16'd6));
        sbq.push_back(ev(1, 2, 8'hE1, 2'd0, 16'd3));
        sbq.push_back(ev(2, 0, 8'hE1, 2'd0, 16'd0));
        m_sw = 8'hE1;
        pulse_go(3);
        wait_start();
        @(negedge clk);
        seq_go = 1; num_steps = 4'd1; cfg_we = 1; cfg_addr = 3'd2; cfg_data = {8'h00, 2'd0, 16'd9};
        @(negedge clk);
        seq_go = 0; cfg_we = 0;
        wait_idle();
        chk("t5_cfg_err", 32'(cfg_err), 32'd1);
        run(1);
        chk("t5_err_clr", 32'(cfg_err), 32'd0);

        // T6: async reset mid-wait, then restart from step 0
        wr(0, 8'hB4, 2'd0, 16'd30);
        sbq.push_back(ev(1, 0, 8'hB4, 2'd0, 16'd30));
        pulse_go(1);
        wait_start();
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_sw", 32'(sw_out), 32'(SAFE));
        chk("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_sw = SAFE;
        run(1);
        chk("t6_sw", 32'(sw_out), 32'hB4);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
